// File: rtl/srlatch_sequencer.sv
// Two-requester sequencer that drives timed set/reset pulses into an external NAND SR latch.
// Define SRLATCH_SEQ_VERIFY_EN to add a synchronized q_fb readback check driving the sticky err flag.
module srlatch_sequencer #(
  parameter int PULSE_W = 4,
  parameter int GUARD_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic op_a,
  output logic ack_a,
  input  logic req_b,
  input  logic op_b,
  output logic ack_b,
  output logic S_n,
  output logic R_n,
  input  logic q_fb,
  output logic busy,
  output logic state_q,
  output logic err
);

  typedef enum logic [1:0] {IDLE, PULSE, GUARD, DONE} fsm_e;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);
  localparam logic [7:0] GUARD_LAST = 8'(GUARD_W - 1);

  fsm_e       fsm_q, fsm_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ptr_q, ptr_d;
  logic       gnt_q, gnt_d;
  logic       op_q, op_d;
  logic       s_n_q, s_n_d;
  logic       r_n_q, r_n_d;
  logic       ack_a_q, ack_a_d;
  logic       ack_b_q, ack_b_d;
  logic       busy_q, busy_d;
  logic       state_d;
  logic       check_done;
  logic       pick_b;

  // B wins when it is the only requester, or when both ask and the pointer favours B.
  assign pick_b = req_b & (~req_a | ptr_q);

  always_comb begin
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    op_d       = op_q;
    s_n_d      = 1'b1;
    r_n_d      = 1'b1;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    busy_d     = busy_q;
    state_d    = state_q;
    check_done = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (req_a || req_b) begin
          gnt_d  = pick_b;
          op_d   = pick_b ? op_b : op_a;
          ptr_d  = ~pick_b;
          cnt_d  = 8'd0;
          fsm_d  = PULSE;
          busy_d = 1'b1;
          s_n_d  = ~op_d;
          r_n_d  = op_d;
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          fsm_d = GUARD;
          cnt_d = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          s_n_d = ~op_q;
          r_n_d = op_q;
        end
      end
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          fsm_d      = DONE;
          cnt_d      = 8'd0;
          ack_a_d    = ~gnt_q;
          ack_b_d    = gnt_q;
          state_d    = op_q;
          check_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        fsm_d  = IDLE;
        busy_d = 1'b0;
      end
      default: begin
        fsm_d  = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      cnt_q   <= 8'd0;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      op_q    <= 1'b0;
      s_n_q   <= 1'b1;
      r_n_q   <= 1'b1;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      busy_q  <= 1'b0;
      state_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      s_n_q   <= s_n_d;
      r_n_q   <= r_n_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      busy_q  <= busy_d;
      state_q <= state_d;
    end
  end

  assign S_n   = s_n_q;
  assign R_n   = r_n_q;
  assign ack_a = ack_a_q;
  assign ack_b = ack_b_q;
  assign busy  = busy_q;

`ifdef SRLATCH_SEQ_VERIFY_EN
  // q_fb is asynchronous; the guard gap of at least two cycles lets it settle through the synchronizer.
  logic q_meta_q, q_sync_q;
  logic err_q, err_d;

  always_ff @(posedge clk) begin
    q_meta_q <= q_fb;
    q_sync_q <= q_meta_q;
  end

  always_comb begin
    err_d = err_q;
    if (check_done && (q_sync_q != op_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_verify;
  assign unused_verify = q_fb ^ check_done;
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_srlatch_sequencer.sv
// Bench for srlatch_sequencer: directed vector table, reset/readback sequences, and
// random requester traffic checked against a transaction-timeline reference model.
module tb_srlatch_sequencer;
  localparam int PW  = 4;
  localparam int GW  = 2;
  localparam int LAT = PW + GW + 1;
`ifdef SRLATCH_SEQ_VERIFY_EN
  localparam logic VER = 1'b1;
`else
  localparam logic VER = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_a = 1'b0, op_a = 1'b0, req_b = 1'b0, op_b = 1'b0;
  logic q_fb;
  logic ack_a, ack_b, S_n, R_n, busy, state_q, err;
  logic latch_v = 1'b0, force_q0 = 1'b0;
  int   total = 0, bad = 0;
  logic exp_state = 1'b0;

  srlatch_sequencer #(.PULSE_W(PW), .GUARD_W(GW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .op_a(op_a), .ack_a(ack_a),
    .req_b(req_b), .op_b(op_b), .ack_b(ack_b),
    .S_n(S_n), .R_n(R_n), .q_fb(q_fb),
    .busy(busy), .state_q(state_q), .err(err)
  );

  always #5 clk = ~clk;

  // Behaviour of the external NAND latch, with an override that pins Q low.
  always @(negedge S_n) latch_v = 1'b1;
  always @(negedge R_n) latch_v = 1'b0;
  assign q_fb = force_q0 ? 1'b0 : latch_v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic ra, oa, rb, ob;
    logic exp_op;   // 1: S_n pulses, 0: R_n pulses
    logic exp_b;    // 1: ack_b expected, 0: ack_a expected
  } vec_t;

  vec_t tbl [7];

  // Starts right after a negedge; runs one full transaction and ends in the IDLE cycle after DONE.
  task automatic run_vec(input vec_t v, input logic err_pre, input logic err_post, input string nm);
    req_a = v.ra; op_a = v.oa; req_b = v.rb; op_b = v.ob;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk({nm, "_sn"},    S_n,   !(v.exp_op && k <= PW));
      chk({nm, "_rn"},    R_n,   !(!v.exp_op && k <= PW));
      chk({nm, "_ack_a"}, ack_a, (k == LAT) && !v.exp_b);
      chk({nm, "_ack_b"}, ack_b, (k == LAT) && v.exp_b);
      chk({nm, "_busy"},  busy,  k <= LAT);
      if (k < LAT)      chk({nm, "_state"}, state_q, exp_state);
      else if (k > LAT) chk({nm, "_state"}, state_q, v.exp_op);
      chk({nm, "_err"},   err,   (k < LAT) ? err_pre : err_post);
      if (k == LAT) begin
        req_a = 1'b0;
        req_b = 1'b0;
      end
    end
    exp_state = v.exp_op;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_state = 1'b0;
  endtask

  // Reference model: each grant opens a fixed timeline of PW low-drive cycles, GW guard
  // cycles and one ack cycle; the next grant is possible two edges after the ack edge.
  int   m_e = 0, m_g = -1000, m_free = 0, m_grants = 0, acks = 0;
  logic m_who = 1'b0, m_op = 1'b0, m_ptr = 1'b0, m_shadow = 1'b0;
  logic pend_a = 1'b0, pend_b = 1'b0;
  int   run_s = 0, run_r = 0;

  task automatic model_step();
    m_e++;
    if (m_e >= m_free && (req_a || req_b)) begin
      m_who    = (req_a && req_b) ? m_ptr : req_b;
      m_op     = m_who ? op_b : op_a;
      m_ptr    = !m_who;
      m_g      = m_e;
      m_free   = m_e + PW + GW + 2;
      m_grants++;
    end
  endtask

  task automatic rnd_cycle(input bit traffic);
    int d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    d = m_e - m_g;
    chk("rnd_sn",    S_n,   !(m_op && d < PW));
    chk("rnd_rn",    R_n,   !(!m_op && d < PW));
    chk("rnd_ack_a", ack_a, (d == PW + GW) && !m_who);
    chk("rnd_ack_b", ack_b, (d == PW + GW) && m_who);
    chk("rnd_busy",  busy,  d <= PW + GW);
    if (d == PW + GW) m_shadow = m_op;
    else              chk("rnd_state", state_q, m_shadow);
    chk("rnd_err",     err,       1'b0);
    chk("rnd_overlap", S_n | R_n, 1'b1);
    if (S_n === 1'b0) run_s++;
    else if (run_s > 0) begin chk("rnd_pulse_s", run_s, PW); run_s = 0; end
    if (R_n === 1'b0) run_r++;
    else if (run_r > 0) begin chk("rnd_pulse_r", run_r, PW); run_r = 0; end
    acks += int'(ack_a === 1'b1) + int'(ack_b === 1'b1);
    if (!traffic) begin
      req_a = 1'b0; req_b = 1'b0; pend_a = 1'b0; pend_b = 1'b0;
    end else begin
      if (ack_a === 1'b1) begin
        pend_a = 1'b0;
        if ($urandom_range(1, 0) == 1) begin
          req_a = 1'b1; op_a = 1'($urandom_range(1, 0)); pend_a = 1'b1;
        end else req_a = 1'b0;
      end else if (!pend_a && $urandom_range(3, 0) == 0) begin
        req_a = 1'b1; op_a = 1'($urandom_range(1, 0)); pend_a = 1'b1;
      end
      if (ack_b === 1'b1) begin
        pend_b = 1'b0;
        if ($urandom_range(1, 0) == 1) begin
          req_b = 1'b1; op_b = 1'($urandom_range(1, 0)); pend_b = 1'b1;
        end else req_b = 1'b0;
      end else if (!pend_b && $urandom_range(3, 0) == 0) begin
        req_b = 1'b1; op_b = 1'($urandom_range(1, 0)); pend_b = 1'b1;
      end
    end
  endtask

  initial begin
    // Pointer starts at A; each grant moves it to the other requester.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};  // A set alone
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};  // B clear alone
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};  // both, pointer A -> A set
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};  // both, pointer B -> B set (redundant)
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // both, pointer A -> A clear
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};  // A alone while pointer is B
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};  // both, pointer B -> B clear

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sn", S_n, 1'b1);
    chk("rst_rn", R_n, 1'b1);
    chk("rst_ack", {ack_a, ack_b}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", state_q, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

    // Reset in the second pulse cycle aborts without ack and drives return high.
    do_reset();
    req_a = 1'b1; op_a = 1'b1;
    @(negedge clk); chk("abort_c1_sn", S_n, 1'b0);
    @(negedge clk); chk("abort_c2_sn", S_n, 1'b0);
    rst_n = 1'b0; req_a = 1'b0;
    @(negedge clk);
    chk("abort_sn", S_n, 1'b1);
    chk("abort_rn", R_n, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_state", state_q, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      chk("abort_noack", {ack_a, ack_b, busy}, 3'b000);
    end

    // Readback mismatch is sticky across a later correct operation until reset.
    do_reset();
    force_q0 = 1'b1;
    run_vec('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b0, VER, "errset");
    force_q0 = 1'b0;
    run_vec('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}, VER, VER, "errhold");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_cleared", err, 1'b0);
    rst_n = 1'b1;
    exp_state = 1'b0;

    do_reset();
    for (int c = 0; c < 10000 && bad < 40; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 2 * LAT + 4; c++) rnd_cycle(1'b0);
    chk("acks_vs_grants", acks, m_grants);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/srlatch_sequencer.md
SRLATCH_SEQUENCER -- requirements
Module: srlatch_sequencer

Interface
REQ-001 The block SHALL have parameter PULSE_W, default 4, giving active-low pulse width in clk cycles (legal 1..255).
REQ-002 The block SHALL have parameter GUARD_W, default 2, giving all-high guard gap after each pulse in clk cycles (legal 2..255).
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 Port list, as name, direction, width and meaning:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_a  input  1  requester A request.
- op_a  input  1  requester A operation: 1 = set, 0 = clear.
- ack_a  output  1  requester A completion, one-cycle pulse.
- req_b  input  1  requester B request.
- op_b  input  1  requester B operation: 1 = set, 0 = clear.
- ack_b  output  1  requester B completion, one-cycle pulse.
- S_n  output  1  active-low set drive to NAND SR latch.
- R_n  output  1  active-low reset drive to NAND SR latch.
- q_fb  input  1  latch Q readback, asynchronous.
- busy  output  1  high whenever FSM not IDLE.
- state_q  output  1  shadow of last commanded latch value.
- err  output  1  sticky readback mismatch flag.

Function
REQ-005 FSM states SHALL be IDLE, PULSE, GUARD, DONE; all outputs registered.
REQ-006 IDLE with any req high at an edge SHALL grant one requester, latch its op, and enter PULSE.
REQ-007 When both request in the same cycle, the grant SHALL go to the round-robin pointer; the pointer SHALL move to the other requester after each grant.
REQ-008 PULSE SHALL last exactly PULSE_W cycles, with S_n=0 (op=1) or R_n=0 (op=0); the other drive stays 1.
REQ-009 GUARD SHALL last exactly GUARD_W cycles with S_n=R_n=1, then enter DONE.
REQ-010 DONE SHALL last one cycle: assert ack of the granted requester only, update state_q to the granted op, and return to IDLE.
REQ-011 Latency SHALL be as follows: grant at edge t gives drive low in cycles t+1..t+PULSE_W and ack high in cycle t+PULSE_W+GUARD_W+1.
REQ-012 S_n and R_n SHALL never be 0 simultaneously in any cycle, including reset entry/exit.
REQ-013 Requesters SHALL hold req and op stable until ack; the block SHALL ignore op changes after grant.
REQ-014 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-015 A redundant operation (op equals state_q) SHALL be executed normally, not skipped.
REQ-016 req changes outside IDLE SHALL have no effect until IDLE.
REQ-017 busy SHALL be 0 only in IDLE.

Reset
REQ-018 When rst_n=0 at an edge, the block SHALL force: FSM IDLE, S_n=1, R_n=1, ack_a=ack_b=0, busy=0, state_q=0, err=0, pointer=A, counters=0.
REQ-019 Reset mid-PULSE or mid-GUARD SHALL abort the operation without ack; the drive SHALL return high on that edge.

Configuration
REQ-020 Macro SRLATCH_SEQ_VERIFY_EN defined SHALL compile in a 2-flop synchronizer on q_fb. In DONE the synchronized q_fb SHALL be compared with the granted op, and err SHALL be set on mismatch, sticky until reset.
REQ-021 Macro SRLATCH_SEQ_VERIFY_EN undefined SHALL omit the synchronizer and compare, tie err to 0, and ignore q_fb; timing SHALL be identical.

Verification
REQ-022 Reset, then req_a=1, op_a=1 at edge 0 -> S_n=0 in cycles 1-4, S_n=R_n=1 in cycles 5-6, ack_a=1 in cycle 7, state_q=1, busy=0 in cycle 8.
REQ-023 req_a and req_b both high with op_a=1, op_b=0, held until ack -> A is served first (ack_a in cycle 7); B is granted next and R_n is low for 4 cycles; ack_b follows, state_q=0.
REQ-024 rst_n=0 in cycle 2 of PULSE -> S_n=R_n=1 on the next edge, no ack, busy=0, state_q unchanged from reset value 0.
REQ-025 Random req/op traffic for 10000 cycles -> S_n&R_n never both 0, exactly one ack per grant, and every pulse is exactly 4 cycles.
REQ-026 With SRLATCH_SEQ_VERIFY_EN defined, a set operation with q_fb held at 0 -> err=1 at DONE and err stays 1 through later correct operations until reset; without the macro, err=0.
